multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the shared single-ported datapath: fetch, decode, execute, memory, writeback.
- Consumes the per-instruction control word produced by the decode stage (RegW, MemW, MemtoReg, FlagW, PCS) plus the condition-check result.
- Emits one-cycle-qualified enables for the PC, instruction register, register file, flags and the data-memory handshake.
- Stretches execute for multi-cycle MULT and counts retired instructions.

Parameters:
- MUL_CYCLES, 3, execute-stage cycles spent on MULT (>=1); all other ALU ops take 1.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; FETCH issues a new instruction only while high
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- reg_w  in  1  decoded RegW
- mem_w  in  1  decoded MemW
- mem_to_reg  in  1  decoded MemtoReg (load)
- flag_w  in  1  decoded FlagW
- pcs  in  1  decoded branch (PCS)
- is_mult  in  1  decoded MULT
- cond_ex  in  1  condition check passed, valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch instruction register
- pc_inc  out  1  PC <= PC+4
- pc_branch  out  1  PC <= branch target
- flag_we  out  1  flags register write enable
- reg_we  out  1  register file write enable
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- busy  out  1  high whenever state != IDLE
- state  out  3  current state encoding
- retired  out  CNT_W  retired-instruction count

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Registered FSM; all outputs are combinational decodes of the state, except retired, which is registered.
- Reset (async, rst_n low): state=IDLE, retired=0, mul_cnt=0. All enable outputs read 0. An in-flight memory request is abandoned; no ack is awaited after reset.
- IDLE:
  - run=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1 every cycle until imem_ack.
  - Cycle with imem_ack=1: ir_write=1 and pc_inc=1 (same cycle), next state DECODE.
- DECODE:
  - Exactly 1 cycle; decoded inputs must be stable from here until the instruction retires. Next state EXEC.
  - mul_cnt loads MUL_CYCLES-1 when is_mult=1, else 0.
- EXEC:
  - Stays while mul_cnt!=0, decrementing by 1 per cycle. A MULT therefore occupies EXEC for exactly MUL_CYCLES cycles.
  - Final EXEC cycle, decided on cond_ex and the decoded word:
    - cond_ex=0 -> retire as no-op, go to FETCH (run=1) or IDLE (run=0); no enable asserted.
    - pcs=1 -> pc_branch=1, retire, go to FETCH/IDLE.
    - flag_w=1 and reg_w=0 and mem_w=0 (CMP) -> flag_we=1, retire, go to FETCH/IDLE.
    - mem_w=1 or mem_to_reg=1 -> MEM.
    - otherwise (ALU op) -> WB. flag_we=flag_w is asserted in the same cycle (ADD/MULT set flags).
- MEM:
  - dmem_req=1 and dmem_we=mem_w, held until dmem_ack.
  - On ack: a store retires and goes to FETCH/IDLE; a load goes to WB.
  - dmem_ack outside MEM is ignored.
- WB:
  - reg_we=reg_w (a load always has reg_w=1), 1 cycle, retire, go to FETCH/IDLE.
- Retire:
  - retired increments by 1 on the cycle the FSM leaves the instruction's last state, including cond-failed no-ops.
  - Wraps modulo 2^CNT_W.
- run is sampled only in IDLE and at retire. Deasserting run mid-instruction completes that instruction, then enters IDLE.
- Never assert pc_inc and pc_branch together. Never assert reg_we and dmem_we together.
- Instruction latency with zero-wait memories: ALU op = FETCH+DECODE+EXEC+WB = 4 cycles; MULT = 3+MUL_CYCLES; store = 4; load = 5; branch/CMP = 3.

Test Plan:
- Reset with run=0, imem_ack=0 -> state=0, every enable 0, retired=0; release reset, hold run=0 10 cycles -> stays IDLE.
- run=1, imem_ack delayed 3 cycles, ADD (reg_w=1, flag_w=1, cond_ex=1) -> imem_req high 4 cycles; ir_write and pc_inc pulse on ack; flag_we in EXEC; reg_we in WB; retired=1 after the 4th post-fetch cycle.
- MULT, MUL_CYCLES=3 -> EXEC occupies exactly 3 cycles, then WB with reg_we=1; total 6 cycles from ack to retire with zero-wait fetch.
- Load (mem_to_reg=1, reg_w=1), dmem_ack after 2 waits -> dmem_req high 3 cycles with dmem_we=0, then reg_we=1 one cycle. Store (mem_w=1) -> dmem_we=1 with dmem_req, no reg_we.
- Branch with cond_ex=0 -> no pc_branch, retired still increments. With cond_ex=1 -> pc_branch one cycle in EXEC, returns to FETCH.
- rst_n asserted mid-MEM with dmem_req high -> dmem_req drops asynchronously, state=IDLE, retired=0. Preset retired to all-ones, retire once -> wraps to 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Multi-cycle control FSM for a shared single-ported datapath. Each
//   instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The FSM
//   emits one-cycle enables for the PC, the instruction register, the
//   register file and the flags, and runs the data-memory handshake.
//   EXEC is stretched to MUL_CYCLES cycles for MULT. A counter tracks
//   retired instructions.
//
// Parameters
//   MUL_CYCLES : number of EXEC cycles spent on a MULT (>= 1)
//   CNT_W      : width of the retired-instruction counter
//
// Ports
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   run          : issue enable, sampled only in IDLE and at retire
//   imem_ack     : instruction memory data valid
//   dmem_ack     : data memory access complete
//   reg_w, mem_w, mem_to_reg, flag_w, pcs, is_mult : decoded control word
//   cond_ex      : condition check result, valid in EXEC
//   imem_req     : instruction fetch request
//   ir_write     : latch the instruction register
//   pc_inc       : PC <= PC + 4
//   pc_branch    : PC <= branch target
//   flag_we      : flags register write enable
//   reg_we       : register file write enable
//   dmem_req     : data memory request
//   dmem_we      : data memory write (qualifies dmem_req)
//   busy         : high whenever the FSM is not in IDLE
//   state        : current state encoding
//   retired      : retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             mem_to_reg,
  input  logic             flag_w,
  input  logic             pcs,
  input  logic             is_mult,
  input  logic             cond_ex,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             flag_we,
  output logic             reg_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  // The counter only ever holds MUL_CYCLES-1 down to 0.
  localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [2:0]       r_state;
  logic [MC_W-1:0]  r_mul_cnt;
  logic [CNT_W-1:0] r_retired;

  logic [2:0]       w_next_state;
  logic [MC_W-1:0]  w_mul_cnt_next;
  logic             w_retire;
  logic             w_exec_last;
  logic             w_is_cmp;
  logic [2:0]       w_ret_state;

  // The last EXEC cycle is the one where the MULT stretch counter has run out.
  assign w_exec_last = (r_mul_cnt == MC_W'(0));
  // A CMP only updates flags. It takes precedence over the memory and WB paths.
  assign w_is_cmp    = flag_w & ~reg_w & ~mem_w;
  // At retire, run decides whether the next fetch starts at once.
  assign w_ret_state = run ? S_FETCH : S_IDLE;

  // Next-state, MULT stretch counter and retire-strobe decode
  always_comb begin
    w_next_state   = r_state;
    w_mul_cnt_next = r_mul_cnt;
    w_retire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        w_next_state = S_EXEC;
        if (is_mult) begin
          w_mul_cnt_next = MC_W'(MUL_CYCLES - 1);
        end else begin
          w_mul_cnt_next = MC_W'(0);
        end
      end
      S_EXEC: begin
        if (!w_exec_last) begin
          w_next_state   = S_EXEC;
          w_mul_cnt_next = r_mul_cnt - MC_W'(1);
        end else if (!cond_ex || pcs || w_is_cmp) begin
          // A no-op, a branch or a CMP finishes here.
          w_retire     = 1'b1;
          w_next_state = w_ret_state;
        end else if (mem_w || mem_to_reg) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (!dmem_ack) begin
          w_next_state = S_MEM;
        end else if (mem_w) begin
          // A store has nothing to write back.
          w_retire     = 1'b1;
          w_next_state = w_ret_state;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        w_retire     = 1'b1;
        w_next_state = w_ret_state;
      end
      default: begin
        w_next_state   = S_IDLE;
        w_mul_cnt_next = MC_W'(0);
      end
    endcase
  end

  // State, MULT counter and retired-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mul_cnt <= MC_W'(0);
      r_retired <= CNT_W'(0);
    end else begin
      r_state   <= w_next_state;
      r_mul_cnt <= w_mul_cnt_next;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  // Enable decode from the current state (plus the same-cycle acks and decoded word)
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    flag_we   = 1'b0;
    reg_we    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
        pc_inc   = imem_ack;
      end
      S_EXEC: begin
        if (w_exec_last && cond_ex) begin
          if (pcs) begin
            pc_branch = 1'b1;
          end else if (w_is_cmp) begin
            flag_we = 1'b1;
          end else if (mem_w || mem_to_reg) begin
            flag_we = 1'b0;
          end else begin
            // An ALU op (ADD or MULT) sets flags on its way to WB.
            flag_we = flag_w;
          end
        end else begin
          pc_branch = 1'b0;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_w;
      end
      S_WB: begin
        reg_we = reg_w;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int TB_MUL   = 3;
  localparam int TB_CNT_W = 8;
  localparam int CNT_MOD  = 1 << TB_CNT_W;

  logic clk = 1'b0;
  logic rst_n, run, imem_ack, dmem_ack;
  logic reg_w, mem_w, mem_to_reg, flag_w, pcs, is_mult, cond_ex;
  logic imem_req, ir_write, pc_inc, pc_branch, flag_we, reg_we, dmem_req, dmem_we, busy;
  logic [2:0] state;
  logic [TB_CNT_W-1:0] retired;

  multicycle_sequencer #(.MUL_CYCLES(TB_MUL), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .reg_w(reg_w), .mem_w(mem_w), .mem_to_reg(mem_to_reg), .flag_w(flag_w), .pcs(pcs),
    .is_mult(is_mult), .cond_ex(cond_ex), .imem_req(imem_req), .ir_write(ir_write),
    .pc_inc(pc_inc), .pc_branch(pc_branch), .flag_we(flag_we), .reg_we(reg_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .busy(busy), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // Expected per-instruction footprint: number of cycles each output is high.
  typedef struct {
    int cyc; int ireq; int irw; int pci; int pcb; int fwe;
    int rwe; int dreq; int dwe; int exe; int dec; int ret;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_count = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: classifies the instruction and derives what it must do.
  function automatic exp_t model(input logic rw, mw, mtr, fw, pb, ml, ce, input int iw, dw);
    exp_t e;
    e = '{default: 0};
    e.exe  = ml ? TB_MUL : 1;
    e.dec  = 1;
    e.ireq = iw + 1;
    e.irw  = 1;
    e.pci  = 1;
    e.cyc  = (iw + 1) + 1 + e.exe;
    if (!ce) begin
      e.pcb = 0;                      // condition failed: no-op
    end else if (pb) begin
      e.pcb = 1;
    end else if (fw && !rw && !mw) begin
      e.fwe = 1;                      // CMP
    end else if (mw) begin
      e.dreq = dw + 1; e.dwe = dw + 1; e.cyc += dw + 1;
    end else if (mtr) begin
      e.dreq = dw + 1; e.rwe = 1; e.cyc += dw + 2;
    end else begin
      e.fwe = fw ? 1 : 0; e.rwe = rw ? 1 : 0; e.cyc += 1;
    end
    return e;
  endfunction

  // Monitor: accumulates activity and checks it against the queue at each retire.
  initial begin : monitor
    exp_t a, e;
    logic [TB_CNT_W-1:0] prev_ret;
    a = '{default: 0};
    prev_ret = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        a = '{default: 0};
        prev_ret = retired;
      end else begin
        if (retired != prev_ret) begin
          if (q.size() == 0) begin
            chk("unexpected_retire", 1, 0);
          end else begin
            e = q.pop_front();
            chk("retired", int'(retired), e.ret);
            chk("latency", a.cyc, e.cyc);
            chk("imem_req_cycles", a.ireq, e.ireq);
            chk("ir_write", a.irw, e.irw);
            chk("pc_inc", a.pci, e.pci);
            chk("pc_branch", a.pcb, e.pcb);
            chk("flag_we", a.fwe, e.fwe);
            chk("reg_we", a.rwe, e.rwe);
            chk("dmem_req_cycles", a.dreq, e.dreq);
            chk("dmem_we_cycles", a.dwe, e.dwe);
            chk("exec_cycles", a.exe, e.exe);
            chk("decode_cycles", a.dec, e.dec);
          end
          a = '{default: 0};
        end
        prev_ret = retired;
        if (busy)      a.cyc++;
        if (imem_req)  a.ireq++;
        if (ir_write)  a.irw++;
        if (pc_inc)    a.pci++;
        if (pc_branch) a.pcb++;
        if (flag_we)   a.fwe++;
        if (reg_we)    a.rwe++;
        if (dmem_req)  a.dreq++;
        if (dmem_we)   a.dwe++;
        if (state == 3'd3) a.exe++;
        if (state == 3'd2) a.dec++;
        chk("pc_inc_and_branch", int'(pc_inc && pc_branch), 0);
        chk("reg_we_and_dmem_we", int'(reg_we && dmem_we), 0);
        chk("busy_vs_state", int'(busy), int'(state != 3'd0));
      end
    end
  end

  // Drives one instruction and plays both memories. Entered at posedge+1.
  task automatic run_instr(input logic rw, mw, mtr, fw, pb, ml, ce,
                           input int iw, dw, input logic run_after);
    exp_t e;
    int icnt, dcnt;
    bit acked, done;
    logic [TB_CNT_W-1:0] start;
    exp_count++;
    e = model(rw, mw, mtr, fw, pb, ml, ce, iw, dw);
    e.ret = exp_count % CNT_MOD;
    q.push_back(e);
    reg_w = rw; mem_w = mw; mem_to_reg = mtr; flag_w = fw;
    pcs = pb; is_mult = ml; cond_ex = ce; run = 1'b1;
    icnt = 0; dcnt = 0; acked = 1'b0; done = 1'b0;
    start = retired;
    for (int c = 0; c < 200 && !done; c++) begin
      imem_ack = imem_req && (icnt == iw);
      if (imem_req) icnt++;
      if (imem_ack) acked = 1'b1;
      else if (acked) run = run_after;
      if (dmem_req) begin
        dmem_ack = (dcnt == dw);
        dcnt++;
      end else begin
        dmem_ack = ($urandom_range(0, 3) == 0);   // stray acks must be ignored
      end
      @(posedge clk); #1;
      done = (retired != start);
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: retired stuck at %0d, expected %0d", retired, e.ret);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  initial begin : stim
    logic rw, mw, mtr, fw, pb, ml, ce, ra;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    reg_w = 1'b0; mem_w = 1'b0; mem_to_reg = 1'b0; flag_w = 1'b0;
    pcs = 1'b0; is_mult = 1'b0; cond_ex = 1'b0;
    #12;
    chk("reset_state", int'(state), 0);
    chk("reset_retired", int'(retired), 0);
    chk("reset_enables", int'({imem_req, ir_write, pc_inc, pc_branch, flag_we,
                                reg_we, dmem_req, dmem_we, busy}), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_hold", int'(state), 0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    //          rw    mw    mtr   fw    pb    ml    ce    iw dw run_after
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 1'b1); // ADD
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1); // MULT
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 1'b1); // load
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b1); // store
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1); // branch, cond fail
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0); // branch taken
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1); // CMP
    // Random mix, long enough to wrap the 8-bit retired counter.
    for (int n = 0; n < 265; n++) begin
      mtr = ($urandom_range(0, 3) == 0);
      mw  = !mtr && ($urandom_range(0, 3) == 0);
      rw  = mtr ? 1'b1 : 1'(($urandom_range(0, 1)));
      fw  = 1'($urandom_range(0, 1));
      pb  = ($urandom_range(0, 4) == 0);
      ml  = ($urandom_range(0, 3) == 0);
      ce  = ($urandom_range(0, 5) != 0);
      ra  = ($urandom_range(0, 7) != 0);
      run_instr(rw, mw, mtr, fw, pb, ml, ce,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ra);
    end
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wrapped_count", int'(retired), exp_count % CNT_MOD);
    chk("count_passed_wrap", int'(exp_count > CNT_MOD), 1);
    chk("queue_drained", q.size(), 0);

    // Asynchronous reset while a store waits in MEM.
    mon_en = 1'b0;
    reg_w = 1'b0; mem_w = 1'b1; mem_to_reg = 1'b0; flag_w = 1'b0;
    pcs = 1'b0; is_mult = 1'b0; cond_ex = 1'b1; run = 1'b1; dmem_ack = 1'b0;
    for (int c = 0; c < 40 && !dmem_req; c++) begin
      imem_ack = imem_req;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    chk("mem_reached", int'(dmem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dmem_req", int'(dmem_req), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_retired", int'(retired), 0);
    run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_count = 0;
    mon_en = 1'b1;
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_retired", int'(retired), 1);
    chk("final_queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
